dpwm_sequencer: RTL and testbench

- Controller in front of the `dpwm` generator in `open_loop`.
- Converts switch-set duty and deadtime settings into DPWM commands: on-time `o_ton`, deadtimes `o_dt1`/`o_dt2`, and enable `o_dp_en`.
- Sequences start, soft-start ramp, run and stop.
- Applies every command change only on the DPWM switching-period boundary (`i_ts_last`), so no period is ever truncated or glitched.

---
 rtl/dpwm_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_dpwm_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/dpwm_sequencer.sv
// Sequencer in front of the dpwm generator: synchronizes switch settings, computes the
// on-time target and walks IDLE/ARM/RAMP/RUN/STOP, changing commands only at period ends.
module dpwm_sequencer #(
   parameter int TS_CNT   = 2000,
   parameter int TON_W    = 11,
   parameter int STEP     = 8,
   parameter int RAMP_DIV = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [7:0]       d_sw,
   input  logic [3:0]       dt1_sw,
   input  logic [3:0]       dt2_sw,
   input  logic             i_ts_last,
   output logic [TON_W-1:0] o_ton,
   output logic [3:0]       o_dt1,
   output logic [3:0]       o_dt2,
   output logic             o_dp_en,
   output logic [2:0]       o_state,
   output logic             o_ramp_done
);

   localparam int PW = 8 + TON_W;
   localparam logic [PW-1:0]    TS_P     = PW'(TS_CNT);
   localparam logic [TON_W-1:0] TS_T     = TON_W'(TS_CNT);
   localparam logic [TON_W:0]   STEP_T   = (TON_W + 1)'(STEP);
   localparam logic [7:0]       DIV_LAST = 8'(RAMP_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ARM  = 3'd1,
      S_RAMP = 3'd2,
      S_RUN  = 3'd3,
      S_STOP = 3'd4
   } state_t;

   // two-flop synchronizers for the asynchronous switch and enable inputs
   logic       en_m, en_s;
   logic [7:0] d_m, d_s;
   logic [3:0] dt1_m, dt1_s, dt2_m, dt2_s;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         en_m  <= 1'b0;
         en_s  <= 1'b0;
         d_m   <= '0;
         d_s   <= '0;
         dt1_m <= '0;
         dt1_s <= '0;
         dt2_m <= '0;
         dt2_s <= '0;
      end else begin
         en_m  <= enable;
         en_s  <= en_m;
         d_m   <= d_sw;
         d_s   <= d_m;
         dt1_m <= dt1_sw;
         dt1_s <= dt1_m;
         dt2_m <= dt2_sw;
         dt2_s <= dt2_m;
      end
   end

   // target = min((d * TS_CNT) >> 8, TS_CNT - dt1 - dt2)
   logic [PW-1:0]    prod;
   logic [TON_W-1:0] raw;
   logic [TON_W-1:0] lim;
   logic [TON_W-1:0] target_d;
   logic [TON_W-1:0] target_q;

   always_comb begin
      prod     = {{TON_W{1'b0}}, d_s} * TS_P;
      raw      = prod[PW-1:8];
      lim      = TS_T - TON_W'(dt1_s) - TON_W'(dt2_s);
      target_d = (raw < lim) ? raw : lim;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) target_q <= '0;
      else      target_q <= target_d;
   end

   state_t           state_q, state_d;
   logic [TON_W-1:0] ton_q, ton_d;
   logic [3:0]       dt1_q, dt1_d, dt2_q, dt2_d;
   logic             dp_en_q, dp_en_d;
   logic [7:0]       cnt_q, cnt_d;
   logic             stop_ph_q, stop_ph_d;
   logic [TON_W:0]   ton_sum;
   logic [TON_W-1:0] ton_stepped;

   // slew-limited increase toward the target
   always_comb begin
      ton_sum     = {1'b0, ton_q} + STEP_T;
      ton_stepped = (ton_sum > {1'b0, target_q}) ? target_q : ton_sum[TON_W-1:0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         ton_q     <= '0;
         dt1_q     <= '0;
         dt2_q     <= '0;
         dp_en_q   <= 1'b0;
         cnt_q     <= '0;
         stop_ph_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ton_q     <= ton_d;
         dt1_q     <= dt1_d;
         dt2_q     <= dt2_d;
         dp_en_q   <= dp_en_d;
         cnt_q     <= cnt_d;
         stop_ph_q <= stop_ph_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ton_d     = ton_q;
      dt1_d     = dt1_q;
      dt2_d     = dt2_q;
      dp_en_d   = dp_en_q;
      cnt_d     = cnt_q;
      stop_ph_d = stop_ph_q;
      case (state_q)
         S_IDLE: begin
            ton_d   = '0;
            dp_en_d = 1'b0;
            if (en_s) begin
               state_d = S_ARM;
               dt1_d   = dt1_s;
               dt2_d   = dt2_s;
               dp_en_d = 1'b1;
            end
         end
         S_ARM: begin
            ton_d = '0;
            if (!en_s) begin
               state_d   = S_STOP;
               stop_ph_d = 1'b0;
            end else if (i_ts_last) begin
               state_d = S_RAMP;
               cnt_d   = '0;
            end
         end
         S_RAMP: begin
            if (!en_s) begin
               state_d   = S_STOP;
               stop_ph_d = 1'b0;
            end else if (i_ts_last) begin
               dt1_d = dt1_s;
               dt2_d = dt2_s;
               if (target_q < ton_q) begin
                  ton_d   = target_q;
                  state_d = S_RUN;
               end else if (cnt_q == DIV_LAST) begin
                  cnt_d = '0;
                  ton_d = ton_stepped;
                  if (ton_stepped >= target_q) state_d = S_RUN;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         S_RUN: begin
            if (!en_s) begin
               state_d   = S_STOP;
               stop_ph_d = 1'b0;
            end else if (i_ts_last) begin
               dt1_d = dt1_s;
               dt2_d = dt2_s;
               ton_d = (target_q > ton_q) ? ton_stepped : target_q;
            end
         end
         S_STOP: begin
            // one full zero-on-time period is emitted before the dpwm is disabled
            if (i_ts_last) begin
               if (!stop_ph_q) begin
                  ton_d     = '0;
                  stop_ph_d = 1'b1;
               end else begin
                  dp_en_d   = 1'b0;
                  stop_ph_d = 1'b0;
                  state_d   = S_IDLE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            ton_d   = '0;
            dp_en_d = 1'b0;
         end
      endcase
   end

   assign o_ton       = ton_q;
   assign o_dt1       = dt1_q;
   assign o_dt2       = dt2_q;
   assign o_dp_en     = dp_en_q;
   assign o_state     = state_q;
   assign o_ramp_done = (state_q == S_RUN);

endmodule

// File: tb/tb_dpwm_sequencer.sv
// Bench for dpwm_sequencer: hand sequences for start, ramp, slew, stop and reset, plus a
// table of switch settings with hand-computed settled on-times checked through a queue.
`timescale 1ns/1ps
module tb_dpwm_sequencer;

   localparam int TON_W = 11;
   localparam int TSP   = 12;  // bench switching period in clk cycles
   localparam int SBW   = TON_W + 8;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             enable = 1'b0;
   logic [7:0]       d_sw = 8'd128;
   logic [3:0]       dt1_sw = 4'd2;
   logic [3:0]       dt2_sw = 4'd2;
   logic             i_ts_last = 1'b0;
   logic [TON_W-1:0] o_ton;
   logic [3:0]       o_dt1, o_dt2;
   logic             o_dp_en;
   logic [2:0]       o_state;
   logic             o_ramp_done;

   dpwm_sequencer #(.TS_CNT(2000), .TON_W(TON_W), .STEP(8), .RAMP_DIV(4)) dut (
      .clk(clk), .rst(rst), .enable(enable), .d_sw(d_sw), .dt1_sw(dt1_sw),
      .dt2_sw(dt2_sw), .i_ts_last(i_ts_last), .o_ton(o_ton), .o_dt1(o_dt1),
      .o_dt2(o_dt2), .o_dp_en(o_dp_en), .o_state(o_state), .o_ramp_done(o_ramp_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [SBW-1:0] exp_q[$];

   typedef struct {
      logic [7:0]       d;
      logic [3:0]       dt1;
      logic [3:0]       dt2;
      logic [TON_W-1:0] ton;
   } vec_t;
   vec_t vecs[8];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic sb_check(input string name);
      logic [SBW-1:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s: scoreboard queue empty", name);
      end else begin
         e = exp_q.pop_front();
         if ({o_ton, o_dt1, o_dt2} !== e) begin
            errors++;
            $display("FAIL %s: got ton=%0d dt1=%0d dt2=%0d expected ton=%0d dt1=%0d dt2=%0d",
                     name, o_ton, o_dt1, o_dt2, e[SBW-1:8], e[7:4], e[3:0]);
         end
      end
   endtask

   // ends on the negedge right after the pulsed posedge
   task automatic run_period();
      repeat (TSP - 1) @(negedge clk);
      i_ts_last = 1'b1;
      @(negedge clk);
      i_ts_last = 1'b0;
   endtask

   initial begin
      vecs[0] = '{d: 8'd0,   dt1: 4'd0,  dt2: 4'd0,  ton: 11'd0};
      vecs[1] = '{d: 8'd1,   dt1: 4'd0,  dt2: 4'd0,  ton: 11'd7};
      vecs[2] = '{d: 8'd255, dt1: 4'd0,  dt2: 4'd0,  ton: 11'd1992};
      vecs[3] = '{d: 8'd255, dt1: 4'd15, dt2: 4'd15, ton: 11'd1970};
      vecs[4] = '{d: 8'd200, dt1: 4'd10, dt2: 4'd5,  ton: 11'd1562};
      vecs[5] = '{d: 8'd255, dt1: 4'd15, dt2: 4'd0,  ton: 11'd1985};
      vecs[6] = '{d: 8'd13,  dt1: 4'd3,  dt2: 4'd7,  ton: 11'd101};
      vecs[7] = '{d: 8'd128, dt1: 4'd2,  dt2: 4'd2,  ton: 11'd1000};

      // reset state
      repeat (3) @(negedge clk);
      chk("reset_ton", o_ton, 0);
      chk("reset_dp_en", o_dp_en, 0);
      chk("reset_state", o_state, 0);
      chk("reset_dt", {o_dt1, o_dt2}, 0);
      rst = 1'b1;
      run_period();
      run_period();
      chk("idle_ignores_ts_state", o_state, 0);
      chk("idle_ignores_ts_ton", o_ton, 0);

      // start: 3-cycle synchronizer latency into ARM
      enable = 1'b1;
      repeat (2) @(negedge clk);
      chk("arm_not_early", o_state, 0);
      repeat (2) @(negedge clk);
      chk("arm_state", o_state, 1);
      chk("arm_dp_en", o_dp_en, 1);
      chk("arm_dt", {o_dt1, o_dt2}, {4'd2, 4'd2});
      chk("arm_ton", o_ton, 0);
      run_period();
      chk("ramp_state", o_state, 2);
      chk("ramp_ton0", o_ton, 0);

      // soft start: +8 every 4 periods up to 1000
      for (int k = 1; k <= 500; k++) begin
         exp_q.push_back({TON_W'(8 * (k / 4)), 4'd2, 4'd2});
         run_period();
         sb_check("ramp_step");
         if (k == 499) chk("ramp_state_499", o_state, 2);
      end
      chk("run_state", o_state, 3);
      chk("run_ramp_done", o_ramp_done, 1);

      // increase clamps to 2000-15-15 and slews +8 per period
      d_sw = 8'd255; dt1_sw = 4'd15; dt2_sw = 4'd15;
      for (int k = 1; k <= 125; k++) begin
         exp_q.push_back({(1000 + 8 * k > 1970) ? 11'd1970 : TON_W'(1000 + 8 * k),
                          4'd15, 4'd15});
         run_period();
         sb_check("slew_up");
      end

      // mid-period decrease waits for the next period boundary
      repeat (3) @(negedge clk);
      d_sw = 8'd64; dt1_sw = 4'd2; dt2_sw = 4'd2;
      repeat (6) @(negedge clk);
      chk("mid_hold_ton", o_ton, 1970);
      chk("mid_hold_dt1", o_dt1, 15);
      repeat (2) @(negedge clk);
      i_ts_last = 1'b1;
      chk("mid_hold_before_edge", o_ton, 1970);
      @(negedge clk);
      i_ts_last = 1'b0;
      chk("mid_ton_500", o_ton, 500);
      chk("mid_dt", {o_dt1, o_dt2}, {4'd2, 4'd2});

      // settled on-time for a table of switch settings
      for (int i = 0; i < 8; i++) begin
         d_sw = vecs[i].d; dt1_sw = vecs[i].dt1; dt2_sw = vecs[i].dt2;
         exp_q.push_back({vecs[i].ton, vecs[i].dt1, vecs[i].dt2});
         repeat (260) run_period();
         sb_check($sformatf("vec%0d", i));
         chk($sformatf("vec%0d_state", i), o_state, 3);
      end

      // stop: one zero-on-time period, then disable; enable re-asserted during STOP
      enable = 1'b0;
      repeat (4) @(negedge clk);
      chk("stop_state", o_state, 4);
      chk("stop_ton_hold", o_ton, 1000);
      chk("stop_dp_en_hold", o_dp_en, 1);
      run_period();
      chk("stop_ton0", o_ton, 0);
      chk("stop_dp_en1", o_dp_en, 1);
      chk("stop_state1", o_state, 4);
      enable = 1'b1;
      d_sw = 8'd0;
      run_period();
      chk("stop_idle_state", o_state, 0);
      chk("stop_idle_dp_en", o_dp_en, 0);
      @(negedge clk);
      chk("rearm_state", o_state, 1);
      chk("rearm_dp_en", o_dp_en, 1);

      // d_sw=0: ARM -> RAMP -> RUN on the first step with zero on-time
      run_period();
      chk("zero_ramp_state", o_state, 2);
      for (int k = 1; k <= 4; k++) begin
         run_period();
         chk("zero_ton", o_ton, 0);
         chk("zero_dp_en", o_dp_en, 1);
         chk("zero_state", o_state, (k == 4) ? 3 : 2);
      end

      // asynchronous reset in the middle of RUN
      d_sw = 8'd128;
      repeat (125) run_period();
      chk("pre_reset_ton", o_ton, 1000);
      #2;
      enable = 1'b0;
      rst = 1'b0;
      #1;
      chk("async_reset_ton", o_ton, 0);
      chk("async_reset_dt", {o_dt1, o_dt2}, 0);
      chk("async_reset_dp_en", o_dp_en, 0);
      chk("async_reset_state", o_state, 0);
      chk("async_reset_done", o_ramp_done, 0);
      @(negedge clk);
      rst = 1'b1;
      run_period();
      chk("post_reset_state", o_state, 0);
      chk("post_reset_dp_en", o_dp_en, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
